// File: rtl/fib_07_unwind_pkg.sv
// Shared types and constants for the fib_07_unwind block.
// Optional invariant monitor is controlled by macro FIB_07_UNWIND_CHECK_EN.
package fib_07_pkg;

  // Default width of every count/data port.
  localparam int W_DEFAULT = 11;

  // Decrement sizes applied per step.
  localparam int STEP_ONE = 1;
  localparam int STEP_TWO = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_07_unwind_if.sv
// Bus bundle between the unwind engine and its driver.
// The inv_ok signal is present only with macro FIB_07_UNWIND_CHECK_EN defined.
//
// Handshake: start is a single-cycle load request with no ready signal. It is
// accepted on any rising edge where state is IDLE or DONE (busy=0) and is
// ignored while busy=1. After acceptance, busy stays high for one cycle per
// remaining step, and done rises when the run finishes or underflows.
interface fib_07_unwind_if
  import fib_07_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic         start;
  logic         selector;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] n_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] i;
  logic         busy;
  logic         done;
  logic         err;
  state_t       state;
`ifdef FIB_07_UNWIND_CHECK_EN
  logic         inv_ok;

  modport master (
    output start, selector, a_in, b_in, n_in,
    input  a, b, i, busy, done, err, state, inv_ok
  );

  modport slave (
    input  start, selector, a_in, b_in, n_in,
    output a, b, i, busy, done, err, state, inv_ok
  );
`else
  modport master (
    output start, selector, a_in, b_in, n_in,
    input  a, b, i, busy, done, err, state
  );

  modport slave (
    input  start, selector, a_in, b_in, n_in,
    output a, b, i, busy, done, err, state
  );
`endif

endinterface

// File: rtl/fib_07_unwind_step.sv
// Single-step datapath: decrements a and b according to selector and flags
// unsigned underflow instead of letting the result wrap.
module fib_07_step
  import fib_07_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         selector,
  output logic [W-1:0] next_a,
  output logic [W-1:0] next_b,
  output logic         underflow
);

  logic [W-1:0] dec_a;
  logic [W-1:0] dec_b;

  // selector=1 takes (a-1, b-2); selector=0 takes (a-2, b-1).
  always_comb begin
    dec_a     = selector ? W'(STEP_ONE) : W'(STEP_TWO);
    dec_b     = selector ? W'(STEP_TWO) : W'(STEP_ONE);
    underflow = (a < dec_a) || (b < dec_b);
    next_a    = a - dec_a;
    next_b    = b - dec_b;
  end

endmodule

// File: rtl/fib_07_unwind.sv
// Unwind engine: loads a, b and a step count, then performs one decrement
// step per cycle until the count reaches zero or a step would underflow.
// With macro FIB_07_UNWIND_CHECK_EN, a registered inv_ok output tracks
// whether a + b == 3 * i holds for the current register values.
module fib_07_unwind
  import fib_07_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  fib_07_unwind_if.slave bus
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] i_q, i_d;
  logic         err_q, err_d;
  logic [W-1:0] step_a;
  logic [W-1:0] step_b;
  logic         step_uf;
  logic         idle_or_done;

  fib_07_step #(.W(W)) u_step (
    .a         (a_q),
    .b         (b_q),
    .selector  (bus.selector),
    .next_a    (step_a),
    .next_b    (step_b),
    .underflow (step_uf)
  );

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

  // State register; reset wins over any load or step.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an underflowing step or the final step ends the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_d = (bus.n_in != '0) ? RUN : DONE;
      end
      RUN: begin
        if (step_uf || (i_q == W'(1))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    bus.state = state_q;
  end

  // Datapath next values: load on accepted start, step while running, hold otherwise.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    i_d   = i_q;
    err_d = err_q;
    if (idle_or_done && bus.start) begin
      a_d   = bus.a_in;
      b_d   = bus.b_in;
      i_d   = bus.n_in;
      err_d = 1'b0;
    end else if (state_q == RUN) begin
      if (step_uf) begin
        err_d = 1'b1;
      end else begin
        a_d = step_a;
        b_d = step_b;
        i_d = i_q - W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      i_q   <= '0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      i_q   <= i_d;
      err_q <= err_d;
    end
  end

  assign bus.a   = a_q;
  assign bus.b   = b_q;
  assign bus.i   = i_q;
  assign bus.err = err_q;

`ifdef FIB_07_UNWIND_CHECK_EN
  logic [W+1:0] sum_ab;
  logic [W+1:0] tri_i;
  logic         inv_q;

  // Evaluated on the next register values so inv_ok lines up with a, b, i.
  always_comb begin
    sum_ab = {2'b00, a_d} + {2'b00, b_d};
    tri_i  = ({2'b00, i_d} << 1) + {2'b00, i_d};
  end

  // Registered invariant flag; the all-zero reset state satisfies it.
  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b1;
    else     inv_q <= (sum_ab == tri_i);
  end

  assign bus.inv_ok = inv_q;
`endif

endmodule

// File: doc/fib_07_unwind.md
FIB_07_UNWIND -- requirements
Module: fib_07_unwind

Interface
REQ-001 Parameter W SHALL be a width parameter, default 11, giving the width of all count/data ports.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  load request; SHALL be sampled only in IDLE or DONE.
REQ-005 a_in, b_in, n_in  input  W each  initial accumulator values and step count.
REQ-006 selector  input  1  per-step mode: 1 = (a-1, b-2), 0 = (a-2, b-1).
REQ-007 a, b, i  output  W each  registered accumulators and remaining-step count.
REQ-008 busy  output  1  SHALL be high exactly while state is RUN.
REQ-009 done  output  1  SHALL be high exactly while state is DONE.
REQ-010 err  output  1  sticky underflow flag; SHALL be cleared only by rst or an accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, and SHALL hold no other state.
REQ-012 IDLE/DONE with start=1: a<=a_in, b<=b_in, i<=n_in, err<=0; next state RUN if n_in!=0, else DONE.
REQ-013 IDLE/DONE with start=0: all registers SHALL hold.
REQ-014 RUN: each cycle SHALL perform exactly one step, i<=i-1, with a and b decremented per selector sampled that cycle.
REQ-015 RUN: start SHALL be ignored.
REQ-016 RUN: a step whose decrement exceeds the current a or b (unsigned underflow) SHALL NOT update a, b or i; it SHALL set err<=1 and go to DONE.
REQ-017 RUN: when i==1 and the step is legal, the step SHALL complete and the next state SHALL be DONE with i==0.
REQ-018 Latency: load at edge k with n_in=N and no error -> done high after edge k+N.
REQ-019 Arithmetic SHALL be unsigned W-bit with no wrap; underflow detection SHALL replace wrap.
REQ-020 If the loaded values satisfy a_in+b_in==3*n_in, then a+b==3*i SHALL hold after every legal step, and err SHALL remain 0.

Reset
REQ-021 rst=1 SHALL force IDLE, a=b=i=0, busy=0, done=0, err=0 at the next edge, including mid-RUN.
REQ-022 rst SHALL take priority over start and over any step.

Configuration
REQ-023 With macro FIB_07_UNWIND_CHECK_EN defined, an output inv_ok (1 bit, registered) SHALL be present, equal to (a+b == 3*i) computed at W+2 bits, and reset to 1.
REQ-024 Without FIB_07_UNWIND_CHECK_EN, inv_ok and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package fib_07_pkg SHALL hold the state enum (IDLE, RUN, DONE), the default width constant 11, and the step-size constants 1 and 2.
REQ-026 Combinational sub-module fib_07_step SHALL take a, b and selector, and SHALL produce next_a, next_b and underflow; fib_07_unwind SHALL instantiate it once.

Verification
REQ-027 a_in=200, b_in=400, n_in=200, selector=1 constant -> busy for 200 cycles, then a=0, b=0, i=0, done=1, err=0.
REQ-028 a_in=300, b_in=300, n_in=200, selector alternating 1/0 -> final a=0, b=0, done=1, err=0; inv_ok=1 every cycle (macro on).
REQ-029 a_in=1, b_in=10, n_in=3, selector=0 -> first RUN cycle sets err=1, done=1, a=1, b=10, i=3 held.
REQ-030 n_in=0 with start -> DONE one edge after load, busy never high, a and b equal to loaded values.
REQ-031 rst asserted mid-RUN (i=57) -> next edge IDLE, all outputs 0; a later start reloads normally.
REQ-032 start pulsed during RUN with different inputs -> ignored, completion matches the original load.
